wb_cmd_master: RTL

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

---
 rtl/wb_cmd_master.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//
// Queues bus commands in a small FIFO and issues them one at a time as
// classic Wishbone single cycles. Each transaction ends on wb_ack_i or when
// the wait counter reaches TIMEOUT, whichever comes first (ack wins a tie).
// Every completion, normal or aborted, produces a one-cycle rsp_valid pulse.
//
// Ports
//   clk_100MHz        sole clock, rising edge
//   reset_n           synchronous active-low reset
//   cmd_valid/ready   command handshake into the FIFO
//   cmd_we/adr/dat/sel command fields (write enable, address, data, selects)
//   wb_cyc_o/stb_o    Wishbone cycle and strobe (registered)
//   wb_we_o/adr_o/dat_o/sel_o  Wishbone command fields (registered)
//   wb_dat_i/ack_i    Wishbone read data and acknowledge
//   rsp_valid         one-cycle completion pulse
//   rsp_dat           read data; 0 for writes and aborts
//   rsp_err           1 when the transaction was aborted by timeout
//   fifo_level        current FIFO occupancy, 0..DEPTH
//   busy              FSM active or FIFO non-empty
// -----------------------------------------------------------------------------
module wb_cmd_master #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk_100MHz,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_we,
    input  logic [ADDR_W-1:0]         cmd_adr,
    input  logic [DATA_W-1:0]         cmd_dat,
    input  logic [DATA_W/8-1:0]       cmd_sel,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [ADDR_W-1:0]         wb_adr_o,
    output logic [DATA_W-1:0]         wb_dat_o,
    output logic [DATA_W/8-1:0]       wb_sel_o,
    input  logic [DATA_W-1:0]         wb_dat_i,
    input  logic                      wb_ack_i,
    output logic                      rsp_valid,
    output logic [DATA_W-1:0]         rsp_dat,
    output logic                      rsp_err,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      busy
);

    localparam int SEL_W   = DATA_W / 8;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W + SEL_W;

    typedef enum logic [1:0] {IDLE, BUS, GAP} state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               push, pop;

    logic               head_we;
    logic [ADDR_W-1:0]  head_adr;
    logic [DATA_W-1:0]  head_dat;
    logic [SEL_W-1:0]   head_sel;

    // A full FIFO refuses a push even if the FSM pops on the same edge.
    assign cmd_ready  = (count != CNT_W'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign fifo_level = count;
    assign {head_we, head_adr, head_dat, head_sel} = mem[rd_ptr];

    // NOTE: the storage array has no reset; count alone decides which
    // entries are live, so flushing only needs the pointers and count.
    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_we, cmd_adr, cmd_dat, cmd_sel};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    state_t             state, state_n;
    logic [WAIT_W-1:0]  wait_cnt, wait_n;
    logic               stb_q, stb_n;
    logic               we_n;
    logic [ADDR_W-1:0]  adr_n;
    logic [DATA_W-1:0]  dat_n;
    logic [SEL_W-1:0]   sel_n;
    logic               rsp_valid_n, rsp_err_n;
    logic [DATA_W-1:0]  rsp_dat_n;
    logic               load_head;

    // cyc and stb always move together for single transfers.
    assign wb_cyc_o = stb_q;
    assign wb_stb_o = stb_q;
    assign busy     = (state != IDLE) || (count != '0);

    // NOTE: every signal gets a default before the case so no path leaves
    // a value unassigned, which would infer a latch.
    always_comb begin
        state_n     = state;
        wait_n      = wait_cnt;
        stb_n       = stb_q;
        we_n        = wb_we_o;
        adr_n       = wb_adr_o;
        dat_n       = wb_dat_o;
        sel_n       = wb_sel_o;
        rsp_valid_n = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_dat_n   = '0;
        pop         = 1'b0;
        load_head   = 1'b0;

        case (state)
            IDLE: begin
                if (count != '0) load_head = 1'b1;
            end
            BUS: begin
                // Ack is tested first so an ack on the timeout edge wins.
                if (wb_ack_i) begin
                    pop         = 1'b1;
                    stb_n       = 1'b0;
                    state_n     = GAP;
                    rsp_valid_n = 1'b1;
                    rsp_dat_n   = wb_we_o ? '0 : wb_dat_i;
                end else if (wait_cnt == WAIT_W'(TIMEOUT)) begin
                    pop         = 1'b1;
                    stb_n       = 1'b0;
                    state_n     = GAP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b1;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            GAP: begin
                if (count != '0) load_head = 1'b1;
                else             state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (load_head) begin
            state_n = BUS;
            stb_n   = 1'b1;
            wait_n  = '0;
            we_n    = head_we;
            adr_n   = head_adr;
            dat_n   = head_dat;
            sel_n   = head_sel;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            stb_q     <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= '0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            stb_q     <= stb_n;
            wb_we_o   <= we_n;
            wb_adr_o  <= adr_n;
            wb_dat_o  <= dat_n;
            wb_sel_o  <= sel_n;
            rsp_valid <= rsp_valid_n;
            rsp_err   <= rsp_err_n;
            rsp_dat   <= rsp_dat_n;
        end
    end

endmodule
